// File: rtl/pac_pkg.sv
// rtl/pac_pkg.sv - shared direction, FSM state and scan-code constants for the sprite motion controller
package pac_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // ST_GAP drops probe_req for one cycle between a failed turn probe and the forward probe
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TURN = 3'd1,
    ST_GAP  = 3'd2,
    ST_FWD  = 3'd3,
    ST_MOVE = 3'd4
  } state_e;

  localparam logic [4:0] KEY_LEFT  = 5'h0C;
  localparam logic [4:0] KEY_RIGHT = 5'h0E;
  localparam logic [4:0] KEY_DOWN  = 5'h09;
  localparam logic [4:0] KEY_UP    = 5'h11;

  localparam logic [7:0] PS2_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_RIGHT = 8'h74;
  localparam logic [7:0] PS2_UP    = 8'h75;
  localparam logic [7:0] PS2_DOWN  = 8'h72;

endpackage

// File: rtl/pac_dir_decode.sv
// rtl/pac_dir_decode.sv - rising-edge capture of keypad/PS/2 codes mapped to a heading, PS/2 first
module pac_dir_decode
  import pac_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_code,
  input  logic       key_ready,
  input  logic [7:0] ps2_code,
  input  logic       ps2_ready,
  output logic       dir_valid,
  output logic [1:0] dir_code
);

  logic       key_ready_q, key_ready_d;
  logic       ps2_ready_q, ps2_ready_d;
  logic       key_known, ps2_known;
  logic       key_hit, ps2_hit;
  logic [1:0] key_dir, ps2_dir;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_ready_q <= 1'b0;
      ps2_ready_q <= 1'b0;
    end else begin
      key_ready_q <= key_ready_d;
      ps2_ready_q <= ps2_ready_d;
    end
  end

  always_comb begin
    key_ready_d = key_ready;
    ps2_ready_d = ps2_ready;

    key_known = 1'b1;
    key_dir   = DIR_UP;
    case (key_code)
      KEY_LEFT:  key_dir = DIR_LEFT;
      KEY_RIGHT: key_dir = DIR_RIGHT;
      KEY_DOWN:  key_dir = DIR_DOWN;
      KEY_UP:    key_dir = DIR_UP;
      default:   key_known = 1'b0;
    endcase

    ps2_known = 1'b1;
    ps2_dir   = DIR_UP;
    case (ps2_code)
      PS2_LEFT:  ps2_dir = DIR_LEFT;
      PS2_RIGHT: ps2_dir = DIR_RIGHT;
      PS2_UP:    ps2_dir = DIR_UP;
      PS2_DOWN:  ps2_dir = DIR_DOWN;
      default:   ps2_known = 1'b0;
    endcase

    // an unrecognised PS/2 code on the same edge does not mask a valid keypad code
    key_hit   = key_known && key_ready && !key_ready_q;
    ps2_hit   = ps2_known && ps2_ready && !ps2_ready_q;
    dir_valid = key_hit || ps2_hit;
    dir_code  = ps2_hit ? ps2_dir : key_dir;
  end

endmodule

// File: rtl/pac_motion_ctrl.sv
// rtl/pac_motion_ctrl.sv - tick-paced sprite mover with wall-probe handshake; PAC_TUNNEL_WRAP_EN wraps x at the bounds
module pac_motion_ctrl
  import pac_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int X_INIT   = 320,
  parameter int Y_INIT   = 146,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 65536,
  parameter int PROBE_TO = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [4:0]     key_code,
  input  logic           key_ready,
  input  logic [7:0]     ps2_code,
  input  logic           ps2_ready,
  output logic           probe_req,
  output logic [X_W-1:0] probe_x,
  output logic [Y_W-1:0] probe_y,
  output logic [1:0]     probe_dir,
  input  logic           probe_ack,
  input  logic           probe_free,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [1:0]     dir,
  output logic [1:0]     pending_dir,
  output logic           moving,
  output logic           step_pulse
);

  localparam int TC_W = $clog2(TICK_DIV);
  localparam int TO_W = $clog2(PROBE_TO + 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(TICK_DIV - 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(PROBE_TO - 1);
  localparam logic [X_W:0]    X_LO_E  = (X_W+1)'(X_MIN + STEP);
  localparam logic [X_W:0]    X_HI_E  = (X_W+1)'(X_MAX);
  localparam logic [X_W:0]    X_STEP  = (X_W+1)'(STEP);
  localparam logic [Y_W:0]    Y_LO_E  = (Y_W+1)'(Y_MIN + STEP);
  localparam logic [Y_W:0]    Y_HI_E  = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0]    Y_STEP  = (Y_W+1)'(STEP);
  localparam logic [X_W-1:0]  X_MIN_V = X_W'(X_MIN);
  localparam logic [X_W-1:0]  X_MAX_V = X_W'(X_MAX);
  localparam logic [Y_W-1:0]  Y_MIN_V = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0]  Y_MAX_V = Y_W'(Y_MAX);

  state_e          state_q, state_d;
  logic [TC_W-1:0] tick_cnt_q, tick_cnt_d;
  logic            tick_pend_q, tick_pend_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [X_W-1:0]  pos_x_q, pos_x_d;
  logic [Y_W-1:0]  pos_y_q, pos_y_d;
  logic [1:0]      dir_q, dir_d;
  logic [1:0]      pending_dir_q, pending_dir_d;
  logic [1:0]      probe_dir_q, probe_dir_d;
  logic            moving_q, moving_d;
  logic            step_pulse_q, step_pulse_d;

  logic            dec_valid;
  logic [1:0]      dec_dir;
  logic            tick, consume, probing, probe_timeout;
  logic [X_W:0]    x_ext, x_up;
  logic [Y_W:0]    y_ext, y_up;

  pac_dir_decode u_dir_decode (
    .clk       (clk),
    .rst       (rst),
    .key_code  (key_code),
    .key_ready (key_ready),
    .ps2_code  (ps2_code),
    .ps2_ready (ps2_ready),
    .dir_valid (dec_valid),
    .dir_code  (dec_dir)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tick_cnt_q    <= '0;
      tick_pend_q   <= 1'b0;
      to_cnt_q      <= '0;
      pos_x_q       <= X_W'(X_INIT);
      pos_y_q       <= Y_W'(Y_INIT);
      dir_q         <= DIR_UP;
      pending_dir_q <= DIR_UP;
      probe_dir_q   <= DIR_UP;
      moving_q      <= 1'b0;
      step_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      tick_pend_q   <= tick_pend_d;
      to_cnt_q      <= to_cnt_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      dir_q         <= dir_d;
      pending_dir_q <= pending_dir_d;
      probe_dir_q   <= probe_dir_d;
      moving_q      <= moving_d;
      step_pulse_q  <= step_pulse_d;
    end
  end

  assign probe_timeout = (to_cnt_q == '0);

  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        ST_IDLE: if (tick_pend_q) state_d = (pending_dir_q != dir_q) ? ST_TURN : ST_FWD;
        ST_TURN: begin
          if (probe_ack)          state_d = probe_free ? ST_MOVE : ST_GAP;
          else if (probe_timeout) state_d = ST_GAP;
        end
        ST_GAP:  state_d = ST_FWD;
        ST_FWD: begin
          if (probe_ack)          state_d = probe_free ? ST_MOVE : ST_IDLE;
          else if (probe_timeout) state_d = ST_IDLE;
        end
        ST_MOVE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    probing = (state_q == ST_TURN) || (state_q == ST_FWD);
    tick    = enable && (tick_cnt_q == TC_LAST);
    consume = enable && (state_q == ST_IDLE) && tick_pend_q;

    tick_cnt_d = tick_cnt_q;
    if (enable) tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    tick_pend_d   = (tick_pend_q && !consume) || (tick && !tick_pend_q);
    pending_dir_d = dec_valid ? dec_dir : pending_dir_q;

    to_cnt_d = to_cnt_q;
    if (enable) begin
      if ((state_d == ST_TURN || state_d == ST_FWD) && state_d != state_q) to_cnt_d = TO_LOAD;
      else if (probing && !probe_timeout) to_cnt_d = to_cnt_q - 1'b1;
    end

    // probe_dir is latched so a new request mid-probe cannot disturb the handshake
    probe_dir_d = probe_dir_q;
    if (consume) probe_dir_d = pending_dir_q;
    else if (enable && state_q == ST_GAP) probe_dir_d = dir_q;

    dir_d = dir_q;
    if (enable && state_q == ST_TURN && state_d == ST_MOVE) dir_d = probe_dir_q;

    moving_d = moving_q;
    if (enable && state_q == ST_MOVE) moving_d = 1'b1;
    else if (enable && state_q == ST_FWD && state_d == ST_IDLE) moving_d = 1'b0;

    step_pulse_d = enable && (state_q == ST_MOVE);

    x_ext   = {1'b0, pos_x_q};
    y_ext   = {1'b0, pos_y_q};
    x_up    = x_ext + X_STEP;
    y_up    = y_ext + Y_STEP;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (enable && state_q == ST_MOVE) begin
      case (dir_q)
        DIR_UP:    pos_y_d = (y_ext < Y_LO_E) ? Y_MIN_V : pos_y_q - Y_W'(STEP);
        DIR_DOWN:  pos_y_d = (y_up > Y_HI_E) ? Y_MAX_V : y_up[Y_W-1:0];
`ifdef PAC_TUNNEL_WRAP_EN
        DIR_LEFT:  pos_x_d = (x_ext < X_LO_E) ? X_MAX_V : pos_x_q - X_W'(STEP);
        DIR_RIGHT: pos_x_d = (x_up > X_HI_E) ? X_MIN_V : x_up[X_W-1:0];
`else
        DIR_LEFT:  pos_x_d = (x_ext < X_LO_E) ? X_MIN_V : pos_x_q - X_W'(STEP);
        DIR_RIGHT: pos_x_d = (x_up > X_HI_E) ? X_MAX_V : x_up[X_W-1:0];
`endif
        default:   pos_x_d = pos_x_q;
      endcase
    end

    probe_req   = probing;
    probe_x     = pos_x_q;
    probe_y     = pos_y_q;
    probe_dir   = probe_dir_q;
    pos_x       = pos_x_q;
    pos_y       = pos_y_q;
    dir         = dir_q;
    pending_dir = pending_dir_q;
    moving      = moving_q;
    step_pulse  = step_pulse_q;
  end

endmodule

// File: tb/tb_pac_motion_ctrl.sv
// tb/tb_pac_motion_ctrl.sv - directed bench for pac_motion_ctrl with a handshaking wall model
module tb_pac_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [4:0] key_code;
  logic       key_ready;
  logic [7:0] ps2_code;
  logic       ps2_ready;
  logic       probe_req, probe_ack, probe_free;
  logic [9:0] probe_x, pos_x;
  logic [8:0] probe_y, pos_y;
  logic [1:0] probe_dir, dir, pending_dir;
  logic       moving, step_pulse;

  int checks = 0;
  int errors = 0;
  bit ack_en = 1'b1;
  bit turn_free = 1'b1;
  bit fwd_free = 1'b1;
  int ack_delay = 1;
  int req_age = 0;
  logic [31:0] x_edge_exp;

  pac_motion_ctrl #(.TICK_DIV(8), .PROBE_TO(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .ps2_code    (ps2_code),
    .ps2_ready   (ps2_ready),
    .probe_req   (probe_req),
    .probe_x     (probe_x),
    .probe_y     (probe_y),
    .probe_dir   (probe_dir),
    .probe_ack   (probe_ack),
    .probe_free  (probe_free),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .dir         (dir),
    .pending_dir (pending_dir),
    .moving      (moving),
    .step_pulse  (step_pulse)
  );

  always #5 clk = ~clk;

  // Wall: answers ack_delay cycles after a request becomes visible, one-cycle ack
  initial begin
    probe_ack  = 1'b0;
    probe_free = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      probe_ack = 1'b0;
      if (probe_req) req_age++;
      else req_age = 0;
      if (probe_req && ack_en && req_age == ack_delay + 1) begin
        probe_ack  = 1'b1;
        probe_free = (probe_dir != dir) ? turn_free : fwd_free;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_req(input logic [7:0] code);
    rst = 1'b1;
    key_ready = 1'b0;
    ps2_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ps2_code = code;
    ps2_ready = 1'b1;
    @(negedge clk);
    ps2_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1;
    key_code = 5'h00; key_ready = 1'b0;
    ps2_code = 8'h00; ps2_ready = 1'b0;

    // 1: reset values, then reset asserted mid-TURN
    repeat (3) @(negedge clk);
    chk("rst_pos_x", pos_x, 320);
    chk("rst_pos_y", pos_y, 146);
    chk("rst_dir", dir, 0);
    chk("rst_pending", pending_dir, 0);
    chk("rst_moving", moving, 0);
    chk("rst_probe_req", probe_req, 0);
    chk("rst_step", step_pulse, 0);
    ack_en = 1'b0;
    reset_req(8'h6B);
    repeat (8) @(negedge clk);
    chk("t1_turn_req", probe_req, 1);
    chk("t1_turn_dir", probe_dir, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("t1_midrst_req", probe_req, 0);
    chk("t1_midrst_pending", pending_dir, 0);
    chk("t1_midrst_pos_x", pos_x, 320);
    chk("t1_midrst_dir", dir, 0);

    // 2: free turn left, ack delay 1
    ack_en = 1'b1; turn_free = 1'b1; fwd_free = 1'b1; ack_delay = 1;
    reset_req(8'h6B);
    chk("t2_pending", pending_dir, 2);
    repeat (8) @(negedge clk);
    chk("t2_req_e9", probe_req, 1);
    @(negedge clk);
    chk("t2_dir_e10", dir, 0);
    @(negedge clk);
    chk("t2_dir_e11", dir, 2);
    chk("t2_x_e11", pos_x, 320);
    @(negedge clk);
    chk("t2_x_e12", pos_x, 319);
    chk("t2_step_e12", step_pulse, 1);
    chk("t2_moving", moving, 1);
    @(negedge clk);
    chk("t2_step_e13", step_pulse, 0);

    // 3: turn blocked, forward free
    turn_free = 1'b0; fwd_free = 1'b1;
    reset_req(8'h6B);
    repeat (8) @(negedge clk);
    chk("t3_turn_dir", probe_dir, 2);
    repeat (2) @(negedge clk);
    chk("t3_gap_req", probe_req, 0);
    @(negedge clk);
    chk("t3_fwd_req", probe_req, 1);
    chk("t3_fwd_dir", probe_dir, 0);
    repeat (3) @(negedge clk);
    chk("t3_pos_y", pos_y, 145);
    chk("t3_pos_x", pos_x, 320);
    chk("t3_dir", dir, 0);
    chk("t3_pending", pending_dir, 2);
    chk("t3_step", step_pulse, 1);

    // 4: both blocked, then no ack at all
    turn_free = 1'b0; fwd_free = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_moving_e21", moving, 1);
    @(negedge clk);
    chk("t4_moving_e22", moving, 0);
    chk("t4_pos_y", pos_y, 145);
    chk("t4_pos_x", pos_x, 320);
    ack_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_to_turn_first", probe_req, 1);
    chk("t4_to_turn_dir", probe_dir, 2);
    repeat (3) @(negedge clk);
    chk("t4_to_turn_last", probe_req, 1);
    @(negedge clk);
    chk("t4_to_turn_drop", probe_req, 0);
    @(negedge clk);
    chk("t4_to_fwd_first", probe_req, 1);
    chk("t4_to_fwd_dir", probe_dir, 0);
    repeat (3) @(negedge clk);
    chk("t4_to_fwd_last", probe_req, 1);
    @(negedge clk);
    chk("t4_to_fwd_drop", probe_req, 0);
    chk("t4_to_moving", moving, 0);

    // 5: capture priority and edge detection
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    key_code = 5'h0E; key_ready = 1'b1; ps2_code = 8'h74; ps2_ready = 1'b1;
    @(negedge clk);
    chk("t5_both_right", pending_dir, 3);
    key_ready = 1'b0; ps2_ready = 1'b0;
    @(negedge clk);
    key_code = 5'h0C; key_ready = 1'b1; ps2_code = 8'h72; ps2_ready = 1'b1;
    @(negedge clk);
    chk("t5_ps2_wins", pending_dir, 1);
    key_ready = 1'b0; ps2_ready = 1'b0;
    @(negedge clk);
    key_code = 5'h11; key_ready = 1'b1; ps2_code = 8'h12; ps2_ready = 1'b1;
    @(negedge clk);
    chk("t5_key_up_ps2_bad", pending_dir, 0);
    key_ready = 1'b0; ps2_ready = 1'b0;
    @(negedge clk);
    key_code = 5'h0C; key_ready = 1'b1;
    @(negedge clk);
    chk("t5_key_left", pending_dir, 2);
    key_code = 5'h0E;
    @(negedge clk);
    chk("t5_level_no_retrig", pending_dir, 2);
    key_ready = 1'b0;

    // 6: walk left to the x bound, then one more step
    ack_en = 1'b1; turn_free = 1'b1; fwd_free = 1'b1;
    reset_req(8'h6B);
    for (int i = 0; i < 3000 && pos_x != 10'd0; i++) @(negedge clk);
    chk("t6_reach_x0", pos_x, 0);
    @(negedge clk);
    for (int i = 0; i < 20 && step_pulse !== 1'b1; i++) @(negedge clk);
`ifdef PAC_TUNNEL_WRAP_EN
    x_edge_exp = 639;
`else
    x_edge_exp = 0;
`endif
    chk("t6_edge_step", step_pulse, 1);
    chk("t6_edge_x", pos_x, x_edge_exp);
    chk("t6_edge_moving", moving, 1);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6_frozen_x", pos_x, x_edge_exp);
    chk("t6_frozen_req", probe_req, 0);
    chk("t6_frozen_step", step_pulse, 0);
    enable = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
